mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator side of the word-addressed data-memory interface (32-bit address, 32-bit data, mem_read/mem_write strobes, registered read data).
- Sits between the MIPS datapath's MEM stage and the data memory.
- Accepts one load/store request at a time and issues the memory transactions for it.
- Memory is word-only, so sub-word stores use read-modify-write. Sub-word loads are extracted and sign- or zero-extended.
- Misaligned accesses are rejected without touching memory.

Parameters:
MEM_LAT, 1, cycles mem_read is held before mem_rdata is sampled (1..7).
ADDR_W, 32, byte-address width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept (high only in IDLE)
req_write  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as misaligned)
req_signed  in  1  loads: 1=sign-extend, 0=zero-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (low bytes used for sub-word)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  formatted load data, valid with resp_valid
resp_err  out  1  misaligned/reserved-size flag, valid with resp_valid
mem_addr  out  32  address to memory, word-aligned (low 2 bits forced 0)
mem_wdata  out  32  write data to memory
mem_read  out  1  read strobe
mem_write  out  1  write strobe
mem_rdata  in  32  read data from memory

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - req_ready=1; resp_valid, resp_err, mem_read and mem_write are 0.
  - resp_rdata, mem_addr and mem_wdata are 0.
  - Reset mid-transaction abandons it. No resp_valid is produced and strobes drop immediately.
- Acceptance: on a rising edge with state IDLE and req_valid=1, all request fields are latched. Inputs are ignored outside IDLE.
- Alignment check at acceptance:
  - half needs addr[0]=0; word needs addr[1:0]=0; size 3 is always misaligned.
  - A misaligned request goes to RESP with resp_err=1 and resp_rdata=0. No strobes are asserted.
- States: IDLE, RD, WR, RESP.
  - IDLE -> RD for a load, or for a byte/half store.
  - IDLE -> WR for a word store.
  - IDLE -> RESP on error.
  - RD: mem_read=1, mem_addr held, wait counter runs MEM_LAT cycles. mem_rdata is captured on the last RD edge. RD -> RESP for a load, RD -> WR for a sub-word store.
  - WR: exactly 1 cycle with mem_write=1. mem_wdata is req_wdata for a word store, or the captured word with the selected byte/half lane replaced. WR -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, req_ready=0. RESP -> IDLE. A new request can be accepted on the edge that leaves RESP+1, i.e. in IDLE.
- mem_read and mem_write are never high together. Both are 0 in IDLE and RESP.
- Latency, counted from the acceptance edge to the resp_valid cycle:
  - load: MEM_LAT+1 cycles
  - word store: 2 cycles
  - sub-word store: MEM_LAT+2 cycles
  - error: 1 cycle
- Lane select is little-endian:
  - byte lane = addr[1:0]; byte k occupies bits 8k+7:8k.
  - half lane = addr[1]; bits 15:0 or 31:16.
- Load formatting:
  - Extracted lane is sign- or zero-extended to 32 bits per req_signed.
  - Word loads pass through; req_signed is ignored.
- Store data: sub-word uses req_wdata[7:0] or [15:0]. Upper bits of req_wdata are ignored.
- resp_rdata is 0 for stores. It holds its value between responses.
- req_ready is combinational from state (IDLE) only. It has no path from req_valid.

Decomposition:
- Shared package mips_mem_pkg holds:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2
  - state encoding for IDLE/RD/WR/RESP
  - MEM_LAT_MAX=7
- One combinational sub-module, mem_lane_fmt, performs:
  - load extraction/extension (word, addr[1:0], size, signed -> 32-bit)
  - store merge (old word, new data, addr[1:0], size -> 32-bit)
- The FSM, counter and registers stay in mem_access_unit.

Test Plan:
- Word load, MEM_LAT=1, memory word 0x100 = 0xDEADBEEF; lw addr 0x100 -> mem_read high 1 cycle with mem_addr=0x100; resp_valid 2 cycles after acceptance; resp_rdata=0xDEADBEEF, resp_err=0.
- Sub-word loads, memory 0x200 = 0x80FF7F01:
  - lb 0x203 signed -> 0xFFFFFF80
  - lbu 0x203 -> 0x00000080
  - lh 0x200 signed -> 0x00007F01
  - lh 0x202 signed -> 0xFFFF80FF
- Byte store RMW, memory 0x300 = 0x11223344; sb addr 0x301 wdata 0xFFFFFFAA -> RD then WR; mem_write with mem_wdata=0x1122AA44; resp at MEM_LAT+2; readback 0x1122AA44.
- Misaligned: lw 0x102, sh 0x101, size=3 -> resp_valid next cycle with resp_err=1, resp_rdata=0; mem_read and mem_write never asserted.
- Back-to-back: req_valid held high with sw then lw to the same address -> second request accepted only in IDLE after RESP; lw returns the stored word; strobes never overlap.
- Reset mid-RD with MEM_LAT=4 (rst_n low in 2nd RD cycle) -> strobes 0 immediately, no resp_valid, req_ready=1 after release; next request completes normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory access path: access sizes,
// access-unit states and the alignment rule applied at request acceptance.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int MEM_LAT_MAX = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Size 3 is reserved and always rejected as if misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Little-endian lane handling for a word-only memory: extracts and extends
// sub-word loads, and merges sub-word store data into the old word.
module mem_lane_fmt
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = rdata_i[{lane_i, 3'b000} +: 8];
    half_v  = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_o  = rdata_i;
    store_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o = {{24{signed_i & byte_v[7]}}, byte_v};
        store_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o = {{16{signed_i & half_v[15]}}, half_v};
        if (lane_i[1]) store_o[31:16] = wdata_i[15:0];
        else           store_o[15:0]  = wdata_i[15:0];
      end
      default: begin
        load_o  = rdata_i;
        store_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator between the MIPS MEM stage and a word-only data memory: one
// request at a time, read-modify-write for sub-word stores, misalignment reject.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = 3;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;

  logic               req_write_q, req_write_d;
  logic               req_signed_q, req_signed_d;
  logic [1:0]         req_size_q, req_size_d;
  logic [1:0]         req_lane_q, req_lane_d;
  logic [31:0]        req_wdata_q, req_wdata_d;

  logic [31:0]        addr_ext;
  logic [31:0]        load_word;
  logic [31:0]        store_word;

  assign addr_ext = 32'(req_addr);

  // Formatter works on the latched request and the live read data, so the
  // result is ready to register on the final RD edge.
  mem_lane_fmt u_fmt (
    .rdata_i  (mem_rdata),
    .wdata_i  (req_wdata_q),
    .lane_i   (req_lane_q),
    .size_i   (req_size_q),
    .signed_i (req_signed_q),
    .load_o   (load_word),
    .store_o  (store_word)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    req_write_d  = req_write_q;
    req_signed_d = req_signed_q;
    req_size_d   = req_size_q;
    req_lane_d   = req_lane_q;
    req_wdata_d  = req_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_write_d  = req_write;
          req_signed_d = req_signed;
          req_size_d   = req_size;
          req_lane_d   = req_addr[1:0];
          req_wdata_d  = req_wdata;
          if (misaligned(req_size, req_addr[1:0])) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            mem_addr_d = addr_ext & 32'hFFFF_FFFC;
            if (req_write && req_size == SZ_WORD) begin
              state_d     = S_WR;
              mem_write_d = 1'b1;
              mem_wdata_d = req_wdata;
            end else begin
              state_d    = S_RD;
              mem_read_d = 1'b1;
              cnt_d      = CNT_W'(MEM_LAT - 1);
            end
          end
        end
      end
      S_RD: begin
        if (cnt_q == '0) begin
          mem_read_d = 1'b0;
          if (req_write_q) begin
            state_d     = S_WR;
            mem_write_d = 1'b1;
            mem_wdata_d = store_word;
          end else begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = load_word;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR: begin
        state_d      = S_RESP;
        mem_write_d  = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Request fields are only meaningful while a transaction is in flight.
  always_ff @(posedge clk) begin
    req_write_q  <= req_write_d;
    req_signed_q <= req_signed_d;
    req_size_q   <= req_size_d;
    req_lane_q   <= req_lane_d;
    req_wdata_q  <= req_wdata_d;
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;

endmodule
